// File: rtl/fir_1to2_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_1to2_demux_pkg                                         |
// | Description : Shared widths and phase encodings for the 1:2 polyphase    |
// |               FIR de-interleaver.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fir_1to2_demux_pkg;

  // Default sample width carried on the input and both output lanes.
  localparam int c_FILTERBITWIDTH_DEFAULT = 20;

  // Default width of the optional saturating slip counter.
  localparam int c_SLIPCNTWIDTH_DEFAULT = 8;

  // Phase encodings: which lane the next accepted sample is steered to.
  localparam logic [0:0] PH_EXPECT_A = 1'b0;
  localparam logic [0:0] PH_EXPECT_B = 1'b1;

endpackage : fir_1to2_demux_pkg
`default_nettype wire

// File: rtl/fir_demux_phase_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_demux_phase_ctrl                                       |
// | Description : Lane phase FSM for the 1:2 de-interleaver. Decides when a  |
// |               sample is held as lane A, when a pair is completed, and    |
// |               when a sync discards a half-filled pair.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fir_demux_phase_ctrl
  import fir_1to2_demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       din_valid,
  output logic [0:0] phase,
  output logic       capture_a,
  output logic       emit_pair,
  output logic       slip
);

  logic [0:0] r_phase;
  logic [0:0] w_phase_nxt;

  // Next-phase decode and per-cycle strobes for the datapath.
  always_comb begin
    w_phase_nxt = r_phase;
    capture_a   = 1'b0;
    emit_pair   = 1'b0;
    slip        = 1'b0;
    case (r_phase)
      PH_EXPECT_A: begin
        // sync is already aligned here; any valid sample simply opens a pair.
        if (din_valid) begin
          capture_a   = 1'b1;
          w_phase_nxt = PH_EXPECT_B;
        end
      end
      default: begin
        if (din_valid && !sync) begin
          emit_pair   = 1'b1;
          w_phase_nxt = PH_EXPECT_A;
        end else if (din_valid && sync) begin
          // The new sample restarts the pair as lane A; phase stays at B.
          capture_a   = 1'b1;
          slip        = 1'b1;
          w_phase_nxt = PH_EXPECT_B;
        end else if (sync) begin
          slip        = 1'b1;
          w_phase_nxt = PH_EXPECT_A;
        end
      end
    endcase
  end

  // Phase register; reset aborts any half-filled pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_EXPECT_A;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  assign phase = r_phase;

endmodule : fir_demux_phase_ctrl
`default_nettype wire

// File: rtl/fir_1to2_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_1to2_demux                                             |
// | Description : Sequential 1:2 de-interleaver. Alternate valid samples are |
// |               steered to lane A (even) and lane B (odd) and emitted as a |
// |               registered pair with a one-cycle pair-valid pulse.         |
// | Options     : FIR_1TO2_DEMUX_SLIPCNT_EN adds a saturating slip counter   |
// |               output (slip_cnt).                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fir_1to2_demux
  import fir_1to2_demux_pkg::*;
#(
  parameter int FILTERBITWIDTH = c_FILTERBITWIDTH_DEFAULT,
  parameter int SLIPCNTWIDTH   = c_SLIPCNTWIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync,
  input  logic                      din_valid,
  input  logic [FILTERBITWIDTH-1:0] din,
  output logic [FILTERBITWIDTH-1:0] dout_a,
  output logic [FILTERBITWIDTH-1:0] dout_b,
  output logic                      dout_valid,
  output logic                      phase,
  output logic                      slip
`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
  ,
  output logic [SLIPCNTWIDTH-1:0]   slip_cnt
`endif
);

  logic                      w_capture_a;
  logic                      w_emit_pair;
  logic                      w_slip;
  logic [0:0]                w_phase;

  logic [FILTERBITWIDTH-1:0] r_hold_a;
  logic [FILTERBITWIDTH-1:0] r_dout_a;
  logic [FILTERBITWIDTH-1:0] r_dout_b;
  logic                      r_dout_valid;
  logic                      r_slip;

  fir_demux_phase_ctrl u_phase_ctrl (
    .clk       (clk),
    .rst       (rst),
    .sync      (sync),
    .din_valid (din_valid),
    .phase     (w_phase),
    .capture_a (w_capture_a),
    .emit_pair (w_emit_pair),
    .slip      (w_slip)
  );

  // Lane A holding register; a sync without a new sample drops the held value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_a <= '0;
    end else if (w_capture_a) begin
      r_hold_a <= din;
    end else if (w_slip) begin
      r_hold_a <= '0;
    end
  end

  // Pair output registers and strobes; the lane outputs hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_a     <= '0;
      r_dout_b     <= '0;
      r_dout_valid <= 1'b0;
      r_slip       <= 1'b0;
    end else begin
      r_dout_valid <= w_emit_pair;
      r_slip       <= w_slip;
      if (w_emit_pair) begin
        r_dout_a <= r_hold_a;
        r_dout_b <= din;
      end
    end
  end

`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
  logic [SLIPCNTWIDTH-1:0] r_slip_cnt;

  // Saturating slip counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slip_cnt <= '0;
    end else if (w_slip && (r_slip_cnt != {SLIPCNTWIDTH{1'b1}})) begin
      r_slip_cnt <= r_slip_cnt + SLIPCNTWIDTH'(1);
    end
  end

  assign slip_cnt = r_slip_cnt;
`else
  // Counter absent in this build; keeps the width parameter referenced.
  logic [SLIPCNTWIDTH-1:0] w_unused_slip_cnt;
  assign w_unused_slip_cnt = '0;
`endif

  assign dout_a     = r_dout_a;
  assign dout_b     = r_dout_b;
  assign dout_valid = r_dout_valid;
  assign phase      = w_phase[0];
  assign slip       = r_slip;

endmodule : fir_1to2_demux
`default_nettype wire

// File: tb/tb_fir_1to2_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fir_1to2_demux                                          |
// | Description : Directed self-checking bench for fir_1to2_demux.           |
// | Options     : FIR_1TO2_DEMUX_SLIPCNT_EN enables the slip counter test.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fir_1to2_demux;

  localparam int W   = 20;
  localparam int SCW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout_a;
  logic [W-1:0] dout_b;
  logic         dout_valid;
  logic         phase;
  logic         slip;
`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
  logic [SCW-1:0] slip_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fir_1to2_demux #(
    .FILTERBITWIDTH (W),
    .SLIPCNTWIDTH   (SCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .din_valid  (din_valid),
    .din        (din),
    .dout_a     (dout_a),
    .dout_b     (dout_b),
    .dout_valid (dout_valid),
    .phase      (phase),
    .slip       (slip)
`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
    ,
    .slip_cnt   (slip_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs; return #1 after the capturing edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic s);
    din_valid = v;
    din       = d;
    sync      = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 20'hABCDE, 1'b1);
    step(1'b1, 20'h12345, 1'b0);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase got=%0h exp=0", phase); end
    checks++; if (dout_a !== '0) begin errors++; $display("FAIL reset_dout_a got=%0h exp=0", dout_a); end
    checks++; if (dout_b !== '0) begin errors++; $display("FAIL reset_dout_b got=%0h exp=0", dout_b); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%0h exp=0", dout_valid); end
    checks++; if (slip !== 1'b0) begin errors++; $display("FAIL reset_slip got=%0h exp=0", slip); end
    rst = 1'b0;
  endtask

  task automatic test_basic_pairs();
    step(1'b1, 20'd1, 1'b0);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL basic_phase1 got=%0h exp=1", phase); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid1 got=%0h exp=0", dout_valid); end
    step(1'b1, 20'd2, 1'b0);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL basic_phase2 got=%0h exp=0", phase); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid2 got=%0h exp=1", dout_valid); end
    checks++; if (dout_a !== 20'd1) begin errors++; $display("FAIL basic_a12 got=%0h exp=1", dout_a); end
    checks++; if (dout_b !== 20'd2) begin errors++; $display("FAIL basic_b12 got=%0h exp=2", dout_b); end
    step(1'b1, 20'd3, 1'b0);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL basic_phase3 got=%0h exp=1", phase); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid3 got=%0h exp=0", dout_valid); end
    checks++; if (dout_a !== 20'd1) begin errors++; $display("FAIL basic_a_hold got=%0h exp=1", dout_a); end
    step(1'b1, 20'd4, 1'b0);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid4 got=%0h exp=1", dout_valid); end
    checks++; if (dout_a !== 20'd3) begin errors++; $display("FAIL basic_a34 got=%0h exp=3", dout_a); end
    checks++; if (dout_b !== 20'd4) begin errors++; $display("FAIL basic_b34 got=%0h exp=4", dout_b); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL basic_phase4 got=%0h exp=0", phase); end
  endtask

  task automatic test_gaps();
    step(1'b1, 20'h00011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 20'hFFFFF, 1'b0);
      checks++; if (dout_valid !== 1'b0 || phase !== 1'b1 || dout_a !== 20'd3 || dout_b !== 20'd4) begin
        errors++;
        $display("FAIL gap_hold[%0d] got v=%0h ph=%0h a=%0h b=%0h exp v=0 ph=1 a=3 b=4",
                 i, dout_valid, phase, dout_a, dout_b);
      end
    end
    step(1'b1, 20'h00022, 1'b0);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got=%0h exp=1", dout_valid); end
    checks++; if (dout_a !== 20'h00011) begin errors++; $display("FAIL gap_a got=%0h exp=11", dout_a); end
    checks++; if (dout_b !== 20'h00022) begin errors++; $display("FAIL gap_b got=%0h exp=22", dout_b); end
    step(1'b0, 20'h0, 1'b0);
    checks++; if (dout_valid !== 1'b0 || dout_a !== 20'h00011 || dout_b !== 20'h00022) begin
      errors++;
      $display("FAIL gap_after got v=%0h a=%0h b=%0h exp v=0 a=11 b=22", dout_valid, dout_a, dout_b);
    end
  endtask

  task automatic test_sync_in_a();
    step(1'b0, 20'h0, 1'b1);
    checks++; if (slip !== 1'b0 || phase !== 1'b0) begin
      errors++; $display("FAIL sync_idle_a got slip=%0h ph=%0h exp slip=0 ph=0", slip, phase);
    end
    step(1'b1, 20'h00033, 1'b1);
    checks++; if (slip !== 1'b0 || phase !== 1'b1) begin
      errors++; $display("FAIL sync_valid_a got slip=%0h ph=%0h exp slip=0 ph=1", slip, phase);
    end
    step(1'b1, 20'h00044, 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout_a !== 20'h00033 || dout_b !== 20'h00044) begin
      errors++; $display("FAIL sync_a_pair got v=%0h a=%0h b=%0h exp v=1 a=33 b=44", dout_valid, dout_a, dout_b);
    end
  endtask

  task automatic test_sync_with_data();
    step(1'b1, 20'd5, 1'b0);
    step(1'b1, 20'd6, 1'b1);
    checks++; if (slip !== 1'b1) begin errors++; $display("FAIL syncd_slip got=%0h exp=1", slip); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL syncd_valid got=%0h exp=0", dout_valid); end
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL syncd_phase got=%0h exp=1", phase); end
    step(1'b1, 20'd7, 1'b0);
    checks++; if (slip !== 1'b0) begin errors++; $display("FAIL syncd_slip_pulse got=%0h exp=0", slip); end
    checks++; if (dout_valid !== 1'b1 || dout_a !== 20'd6 || dout_b !== 20'd7) begin
      errors++; $display("FAIL syncd_pair got v=%0h a=%0h b=%0h exp v=1 a=6 b=7", dout_valid, dout_a, dout_b);
    end
  endtask

  task automatic test_sync_alone();
    step(1'b1, 20'd9, 1'b0);
    step(1'b0, 20'h0, 1'b1);
    checks++; if (slip !== 1'b1) begin errors++; $display("FAIL synca_slip got=%0h exp=1", slip); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL synca_phase got=%0h exp=0", phase); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL synca_valid got=%0h exp=0", dout_valid); end
    step(1'b1, 20'd10, 1'b0);
    checks++; if (slip !== 1'b0 || phase !== 1'b1 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL synca_a got slip=%0h ph=%0h v=%0h exp slip=0 ph=1 v=0", slip, phase, dout_valid);
    end
    step(1'b1, 20'd11, 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout_a !== 20'd10 || dout_b !== 20'd11) begin
      errors++; $display("FAIL synca_pair got v=%0h a=%0h b=%0h exp v=1 a=a b=b", dout_valid, dout_a, dout_b);
    end
  endtask

  task automatic test_reset_midpair();
    step(1'b1, 20'hFFFFF, 1'b0);
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL rstm_phase_pre got=%0h exp=1", phase); end
    rst = 1'b1;
    step(1'b1, 20'h00077, 1'b0);
    checks++; if (phase !== 1'b0 || dout_a !== '0 || dout_b !== '0 || dout_valid !== 1'b0 || slip !== 1'b0) begin
      errors++;
      $display("FAIL rstm_outputs got ph=%0h a=%0h b=%0h v=%0h slip=%0h exp all 0",
               phase, dout_a, dout_b, dout_valid, slip);
    end
    rst = 1'b0;
    step(1'b1, 20'd1, 1'b0);
    checks++; if (dout_valid !== 1'b0 || phase !== 1'b1) begin
      errors++; $display("FAIL rstm_first got v=%0h ph=%0h exp v=0 ph=1", dout_valid, phase);
    end
    step(1'b1, 20'd2, 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout_a !== 20'd1 || dout_b !== 20'd2) begin
      errors++; $display("FAIL rstm_pair got v=%0h a=%0h b=%0h exp v=1 a=1 b=2", dout_valid, dout_a, dout_b);
    end
  endtask

`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
  task automatic test_slip_cnt();
    logic [SCW-1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    rst = 1'b1;
    step(1'b0, 20'h0, 1'b0);
    rst = 1'b0;
    checks++; if (slip_cnt !== '0) begin errors++; $display("FAIL slipcnt_reset got=%0d exp=0", slip_cnt); end
    step(1'b1, 20'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'(i + 2), 1'b1);
      checks++; if (slip_cnt !== exp_cnt[i] || slip !== 1'b1) begin
        errors++; $display("FAIL slipcnt[%0d] got cnt=%0d slip=%0h exp cnt=%0d slip=1", i, slip_cnt, slip, exp_cnt[i]);
      end
    end
    step(1'b1, 20'd9, 1'b0);
    checks++; if (slip_cnt !== 2'd3 || dout_valid !== 1'b1 || dout_a !== 20'd6) begin
      errors++; $display("FAIL slipcnt_hold got cnt=%0d v=%0h a=%0h exp cnt=3 v=1 a=6", slip_cnt, dout_valid, dout_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pairs();
    test_gaps();
    test_sync_in_a();
    test_sync_with_data();
    test_sync_alone();
    test_reset_midpair();
`ifdef FIR_1TO2_DEMUX_SLIPCNT_EN
    test_slip_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fir_1to2_demux
`default_nettype wire

// File: doc/fir_1to2_demux.md
Name: fir_1to2_demux

Overview:
- Sequential 1:2 de-interleaver for the polyphase FIR path. It is the inverse of the 2:1 lane multiplexer.
- Accepts a serial sample stream with a valid qualifier and steers alternate samples to lane A (even) and lane B (odd).
- Emits each A/B pair together, registered, with a one-cycle pair-valid pulse.
- Sits ahead of the two half-rate FIR sub-filters; a sync input realigns the phase to lane A.

Parameters:
- FILTERBITWIDTH, 20, sample width in bits on input and both output lanes.
- SLIPCNTWIDTH, 8, width of the optional slip counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sync  input  1  frame alignment; the next accepted sample (or idle phase) is forced to lane A.
- din_valid  input  1  din carries a sample this cycle.
- din  input  FILTERBITWIDTH  input sample.
- dout_a  output  FILTERBITWIDTH  lane A (even) sample of the last completed pair.
- dout_b  output  FILTERBITWIDTH  lane B (odd) sample of the last completed pair.
- dout_valid  output  1  one-cycle pulse: dout_a/dout_b updated this cycle.
- phase  output  1  0 = next sample goes to lane A; 1 = lane A held, awaiting lane B.
- slip  output  1  one-cycle pulse: sync discarded a half-filled pair.
- slip_cnt  output  SLIPCNTWIDTH  saturating slip count; present only with FIR_1TO2_DEMUX_SLIPCNT_EN.

Behaviour:
- Reset (rst=1 at a clk edge): phase=0, hold_a=0, dout_a=0, dout_b=0, dout_valid=0, slip=0, slip_cnt=0. Reset has priority over all inputs and aborts any half-filled pair.
- All outputs are registered; no combinational path from input to output.
- State machine phase:
  - EXPECT_A (0): on din_valid & !sync, hold_a<=din, go to EXPECT_B.
  - EXPECT_B (1): on din_valid & !sync, next cycle dout_a<=hold_a, dout_b<=din, dout_valid=1; go to EXPECT_A.
- Latency: dout_valid is asserted one clk after the cycle in which the lane-B sample is accepted.
- dout_a and dout_b hold their values between pulses. dout_valid is never high two cycles in a row unless B samples are accepted on consecutive cycles, which is impossible (needs A between), so minimum pulse spacing is 2 cycles.
- din_valid=0: no state change; the held A sample is retained indefinitely (gaps of any length allowed).
- sync & din_valid in EXPECT_A: normal lane-A accept; no slip.
- sync & din_valid in EXPECT_B: hold_a is discarded and din is captured as the new hold_a. Phase stays 1, slip=1 next cycle, no dout_valid.
- sync & !din_valid in EXPECT_B: go to EXPECT_A, discard hold_a, slip=1 next cycle.
- sync & !din_valid in EXPECT_A: no effect, no slip.
- Data is passed through unmodified: no arithmetic, no sign handling, width preserved.

Optional Feature:
- Macro: FIR_1TO2_DEMUX_SLIPCNT_EN.
- Defined:
  - slip_cnt port exists.
  - It increments on every slip event and saturates at all-ones.
  - It clears only on rst.
- Undefined:
  - Port and counter are absent.
  - slip pulse behaviour is unchanged.

Decomposition:
- Shared package/include holds:
  - FILTERBITWIDTH default (20).
  - Phase encodings PH_EXPECT_A=1'b0, PH_EXPECT_B=1'b1.
  - SLIPCNTWIDTH default.
- One natural sub-module: fir_demux_phase_ctrl.
  - Owns the phase FSM and sync/slip logic.
  - Outputs capture_a, emit_pair and slip strobes.
- The datapath registers stay in the top module.

Test Plan:
- Reset, then din_valid on consecutive cycles with din=1,2,3,4 -> dout_valid pulses the cycle after 2 (a=1, b=2) and after 4 (a=3, b=4); phase toggles 0,1,0,1.
- din=0x00011 valid, 5 idle cycles, din=0x00022 valid -> single dout_valid with a=0x00011, b=0x00022; dout_a/dout_b hold between pulses.
- din=5 valid, then sync with din=6 valid, then din=7 valid -> slip pulse once, no pair (5,x), next pair a=6, b=7.
- din=9 valid, then sync alone, then din=10,11 valid -> slip pulse, phase=0 after sync, pair a=10, b=11.
- rst asserted while phase=1 (after din=0xFFFFF), then din=1,2 -> all outputs 0 during reset, no pair containing 0xFFFFF, pair a=1, b=2.
- With FIR_1TO2_DEMUX_SLIPCNT_EN and SLIPCNTWIDTH=2: 5 slip events -> slip_cnt 1,2,3,3,3.
